fetch_predict_unit: RTL and testbench

- Parametrised instruction-fetch front end: owns the PC register, next-PC selection, and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Replaces the fixed PC mux / PC register / PC increment chain of the single-cycle core.
- Feeds the instruction memory address and supplies a predicted next PC.
- Execute-stage resolution corrects mispredictions via redirect and trains the BTB.

---
 rtl/fetch_predict_unit.sv | 106 ++++++++++
 tb/tb_fetch_predict_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_predict_unit.sv
// Instruction-fetch front end: PC register, next-PC select, direct-mapped BTB
// with 2-bit saturating counters, and a saturating mispredict counter.
module fetch_predict_unit #(
    parameter int                  PC_WIDTH     = 32,
    parameter int                  BTB_ENTRIES  = 16,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                  CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_i,
    input  logic                 redirect_i,
    input  logic [PC_WIDTH-1:0]  redirect_pc_i,
    input  logic                 resolve_valid_i,
    input  logic [PC_WIDTH-1:0]  resolve_pc_i,
    input  logic                 resolve_taken_i,
    input  logic [PC_WIDTH-1:0]  resolve_target_i,
    output logic [PC_WIDTH-1:0]  pc_o,
    output logic [PC_WIDTH-1:0]  pc_plus4_o,
    output logic                 pred_taken_o,
    output logic [PC_WIDTH-1:0]  pred_target_o,
    output logic [CNT_WIDTH-1:0] mispredict_count_o
);

    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = PC_WIDTH - IDX - 2;
    localparam logic [PC_WIDTH-1:0] FOUR = PC_WIDTH'(4);

    logic [PC_WIDTH-1:0]                  pc_q, pc_d;
    logic [BTB_ENTRIES-1:0]               valid_q, valid_d;
    logic [BTB_ENTRIES-1:0][TAG_W-1:0]    tag_q, tag_d;
    logic [BTB_ENTRIES-1:0][PC_WIDTH-1:0] target_q, target_d;
    logic [BTB_ENTRIES-1:0][1:0]          ctr_q, ctr_d;
    logic [CNT_WIDTH-1:0]                 cnt_q, cnt_d;

    logic [IDX-1:0]   l_idx, r_idx;
    logic [TAG_W-1:0] l_tag, r_tag;
    logic             l_hit, r_hit;
    logic             unused_resolve_lsbs;

    assign l_idx = pc_q[IDX+1:2];
    assign l_tag = pc_q[PC_WIDTH-1:IDX+2];
    assign r_idx = resolve_pc_i[IDX+1:2];
    assign r_tag = resolve_pc_i[PC_WIDTH-1:IDX+2];
    assign unused_resolve_lsbs = ^resolve_pc_i[1:0];

    assign l_hit = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    assign r_hit = valid_q[r_idx] && (tag_q[r_idx] == r_tag);

    assign pc_o               = pc_q;
    assign pc_plus4_o         = pc_q + FOUR;
    assign pred_taken_o       = l_hit && ctr_q[l_idx][1];
    assign pred_target_o      = pred_taken_o ? target_q[l_idx] : pc_plus4_o;
    assign mispredict_count_o = cnt_q;

    always_comb begin
        pc_d     = pc_q;
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        cnt_d    = cnt_q;

        if (redirect_i)        pc_d = redirect_pc_i;
        else if (!stall_i)     pc_d = pred_target_o;

        // Training writes state only; the lookup above always sees the old entry.
        if (resolve_valid_i) begin
            if (r_hit) begin
                if (resolve_taken_i) begin
                    target_d[r_idx] = resolve_target_i;
                    if (ctr_q[r_idx] != 2'b11) ctr_d[r_idx] = ctr_q[r_idx] + 2'd1;
                end else if (ctr_q[r_idx] != 2'b00) begin
                    ctr_d[r_idx] = ctr_q[r_idx] - 2'd1;
                end
            end else if (resolve_taken_i) begin
                valid_d[r_idx]  = 1'b1;
                tag_d[r_idx]    = r_tag;
                target_d[r_idx] = resolve_target_i;
                ctr_d[r_idx]    = 2'b10;
            end
        end

        if (redirect_i && (cnt_q != {CNT_WIDTH{1'b1}}))
            cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_VECTOR;
            valid_q  <= '0;
            tag_q    <= '0;
            target_q <= '0;
            ctr_q    <= {BTB_ENTRIES{2'b01}};
            cnt_q    <= '0;
        end else begin
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fetch_predict_unit.sv
// Directed bench for fetch_predict_unit: sequencing, BTB training, aliasing,
// saturation, PC wrap and asynchronous reset.
module tb_fetch_predict_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        resolve_valid_i = 1'b0;
    logic [31:0] resolve_pc_i = '0;
    logic        resolve_taken_i = 1'b0;
    logic [31:0] resolve_target_i = '0;

    logic [31:0] pc_o, pc_plus4_o, pred_target_o;
    logic        pred_taken_o;
    logic [15:0] mispredict_count_o;

    logic [31:0] pc2_o, pc2_plus4_o, pred2_target_o;
    logic        pred2_taken_o;
    logic [1:0]  cnt2_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_predict_unit dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .resolve_valid_i(resolve_valid_i),
        .resolve_pc_i(resolve_pc_i), .resolve_taken_i(resolve_taken_i),
        .resolve_target_i(resolve_target_i), .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
        .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
        .mispredict_count_o(mispredict_count_o)
    );

    fetch_predict_unit #(.CNT_WIDTH(2)) dut_c2 (
        .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .resolve_valid_i(resolve_valid_i),
        .resolve_pc_i(resolve_pc_i), .resolve_taken_i(resolve_taken_i),
        .resolve_target_i(resolve_target_i), .pc_o(pc2_o), .pc_plus4_o(pc2_plus4_o),
        .pred_taken_o(pred2_taken_o), .pred_target_o(pred2_target_o),
        .mispredict_count_o(cnt2_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_i = 1'b1; redirect_pc_i = pc;
        step();
        redirect_i = 1'b0;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        resolve_valid_i = 1'b1; resolve_pc_i = pc;
        resolve_taken_i = tk; resolve_target_i = tgt;
        step();
        resolve_valid_i = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_plus4", pc_plus4_o, 32'h4);
        chk("rst_ptgt", pred_target_o, 32'h4);
        chk("rst_ptk", {31'b0, pred_taken_o}, 32'h0);
        chk("rst_cnt", {16'b0, mispredict_count_o}, 32'h0);
        step();
        rst = 1'b0;
        chk("rel_pc", pc_o, 32'h0);

        // Free-running sequential fetch
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("seq_pc", pc_o, 32'(i * 4));
            chk("seq_ptk", {31'b0, pred_taken_o}, 32'h0);
        end

        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", pc_o, 32'h10);
        end
        redirect_to(32'h40);
        chk("redir_over_stall", pc_o, 32'h40);
        chk("cnt1", {16'b0, mispredict_count_o}, 32'h1);

        // Train while stalled: PC holds, BTB still learns
        resolve(32'h10, 1'b1, 32'h100);
        chk("train_stall_pc", pc_o, 32'h40);
        redirect_to(32'h10);
        chk("hit_ptk", {31'b0, pred_taken_o}, 32'h1);
        chk("hit_ptgt", pred_target_o, 32'h100);
        stall_i = 1'b0;
        step();
        chk("follow_pred", pc_o, 32'h100);

        // Three not-taken: 2->1->0->0
        stall_i = 1'b1;
        resolve(32'h10, 1'b0, 32'h0);
        resolve(32'h10, 1'b0, 32'h0);
        resolve(32'h10, 1'b0, 32'h0);
        redirect_to(32'h10);
        chk("nt_ptk", {31'b0, pred_taken_o}, 32'h0);
        chk("nt_ptgt", pred_target_o, 32'h14);
        stall_i = 1'b0;
        step();
        chk("nt_pc", pc_o, 32'h14);

        // Aliasing: 0x10 and 0x50 share index 4
        stall_i = 1'b1;
        resolve(32'h10, 1'b1, 32'h100);
        resolve(32'h10, 1'b1, 32'h100);
        resolve(32'h50, 1'b1, 32'h200);
        redirect_to(32'h10);
        chk("alias_old_ptk", {31'b0, pred_taken_o}, 32'h0);
        redirect_to(32'h50);
        chk("alias_new_ptk", {31'b0, pred_taken_o}, 32'h1);
        chk("alias_new_ptgt", pred_target_o, 32'h200);
        chk("cnt5", {16'b0, mispredict_count_o}, 32'h5);
        chk("cnt2_sat", {30'b0, cnt2_o}, 32'h3);
        stall_i = 1'b0;
        step();
        chk("alias_pc", pc_o, 32'h200);

        // Counter saturates at 3: after four taken, one not-taken still predicts taken
        stall_i = 1'b1;
        for (int i = 0; i < 4; i++) resolve(32'h50, 1'b1, 32'h300);
        resolve(32'h50, 1'b0, 32'h0);
        redirect_to(32'h50);
        chk("sat_ptk", {31'b0, pred_taken_o}, 32'h1);
        chk("sat_ptgt", pred_target_o, 32'h300);

        // PC wrap
        stall_i = 1'b0;
        redirect_to(32'hFFFF_FFFC);
        chk("wrap_pc", pc_o, 32'hFFFF_FFFC);
        chk("wrap_plus4", pc_plus4_o, 32'h0);
        step();
        chk("wrap_next", pc_o, 32'h0);

        // Same-cycle train of current PC: no bypass, so fetch goes sequential
        resolve(32'h0, 1'b1, 32'h80);
        chk("nobypass_pc", pc_o, 32'h4);
        stall_i = 1'b1;
        redirect_to(32'h0);
        chk("nobypass_ptgt", pred_target_o, 32'h80);
        chk("cnt2_hold", {30'b0, cnt2_o}, 32'h3);

        // Async reset mid-redirect while pc=0x50 (trained)
        redirect_to(32'h50);
        chk("pre_rst_ptk", {31'b0, pred_taken_o}, 32'h1);
        redirect_i = 1'b1; redirect_pc_i = 32'h100;
        step();
        chk("pre_rst_pc", pc_o, 32'h100);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_pc", pc_o, 32'h0);
        chk("arst_cnt", {16'b0, mispredict_count_o}, 32'h0);
        chk("arst_ptk", {31'b0, pred_taken_o}, 32'h0);
        redirect_i = 1'b0;
        #4;
        rst = 1'b0;
        redirect_to(32'h50);
        chk("post_rst_ptk", {31'b0, pred_taken_o}, 32'h0);
        chk("post_rst_ptgt", pred_target_o, 32'h54);
        chk("post_rst_cnt", {16'b0, mispredict_count_o}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
